// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 mux datapath.
// Registered one-hot grant and binary select, with a bounded hold time per owner.
module rr_mux_arbiter #(
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   y,
  output logic            busy
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n, sel_n, win, next_ptr;
  logic [3:0]    gnt_n, others;
  logic          busy_n, owner_req, at_limit;
  logic [HW-1:0] hold_cnt, hold_n;

  // First asserted request in the order start, start+1, start+2, start+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = start + 2'(k - 1);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    gnt_n     = gnt;
    busy_n    = busy;
    hold_n    = hold_cnt;
    win       = '0;
    next_ptr  = sel + 2'd1;
    others    = req & ~gnt;
    owner_req = |(req & gnt);
    at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    case (state)
      IDLE: begin
        if (|req) begin
          win     = rr_pick(req, ptr);
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          busy_n  = 1'b1;
          hold_n  = HW'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        // Release and preemption share one path: the owner goes to the back of the line.
        if (!owner_req || (at_limit && |others)) begin
          ptr_n = next_ptr;
          if (|others) begin
            win    = rr_pick(others, next_ptr);
            gnt_n  = 4'b0001 << win;
            sel_n  = win;
            hold_n = HW'(1);
          end else begin
            gnt_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    y = '0;
    if (busy) y = in_data[sel*DW +: DW];
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus a randomized
// run compared against a round-robin reference model.
module tb_rr_mux_arbiter;
  localparam int unsigned DW = 4;
  localparam int unsigned MH = 2;
  localparam int unsigned IW = 4 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [IW-1:0] in_data;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int m_owner, m_ptr, m_cnt;

  rr_mux_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data),
    .gnt(gnt), .sel(sel), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane(input logic [IW-1:0] d, input int idx);
    return d[idx*DW +: DW];
  endfunction

  function automatic int search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int o;
    logic [3:0] rest;
    o = m_owner;
    if (o < 0) begin
      if (r != 4'b0) begin
        m_owner = search(r, m_ptr);
        m_cnt   = 1;
      end
    end else begin
      rest = r & ~(4'b0001 << o);
      if (!r[o] || (m_cnt == MH && rest != 4'b0)) begin
        m_ptr = (o + 1) % 4;
        if (rest != 4'b0) begin
          m_owner = search(rest, m_ptr);
          m_cnt   = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_cnt < MH) begin
        m_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0;
    in_data = IW'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({gnt, sel, busy, y} !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: gnt=%b sel=%0d busy=%b y=%h, required all zero", i, gnt, sel, busy, y);
      end
    end
  endtask

  task automatic test_all_req();
    logic [3:0] seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    int idx [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    in_data = IW'($urandom);
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (gnt !== seq[i]) begin
        bad++;
        $display("FAIL all_req_gnt step %0d: got %b, required %b", i, gnt, seq[i]);
      end
      total++;
      if (sel !== 2'(idx[i])) begin
        bad++;
        $display("FAIL all_req_sel step %0d: got %0d, required %0d", i, sel, idx[i]);
      end
      in_data = IW'($urandom);
      #1;
      total++;
      if (y !== lane(in_data, idx[i])) begin
        bad++;
        $display("FAIL all_req_y step %0d: got %h, required %h", i, y, lane(in_data, idx[i]));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    in_data = IW'($urandom);
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
        bad++;
        $display("FAIL single_gnt cycle %0d: gnt=%b busy=%b, required 0100 1", i, gnt, busy);
      end
      total++;
      if (dut.hold_cnt !== 2'((i + 1 < 2) ? i + 1 : 2)) begin
        bad++;
        $display("FAIL single_hold cycle %0d: got %0d, required %0d", i, dut.hold_cnt, (i + 1 < 2) ? i + 1 : 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_data = IW'($urandom);
    req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL b2b_first: got %b, required 0010", gnt);
    end
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000 || busy !== 1'b1 || sel !== 2'd3) begin
      bad++;
      $display("FAIL b2b_handover: gnt=%b busy=%b sel=%0d, required 1000 1 3", gnt, busy, sel);
    end
    total++;
    if (y !== lane(in_data, 3)) begin
      bad++;
      $display("FAIL b2b_y: got %h, required %h", y, lane(in_data, 3));
    end
    req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || y !== '0) begin
      bad++;
      $display("FAIL b2b_idle: gnt=%b busy=%b y=%h, required 0000 0 0", gnt, busy, y);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_data = IW'($urandom);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL arst_pre: got %b, required 0001", gnt);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || y !== '0) begin
      bad++;
      $display("FAIL arst_drop: gnt=%b busy=%b sel=%0d y=%h, required all zero", gnt, busy, sel, y);
    end
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL arst_held: got %b, required 0000", gnt);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL arst_regrant: gnt=%b sel=%0d busy=%b, required 1000 3 1", gnt, sel, busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt, prev_gnt;
    int wait_cnt [4] = '{0, 0, 0, 0};
    do_reset();
    prev_gnt = 4'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      in_data = IW'($urandom);
      @(posedge clk);
      model_edge(req);
      @(negedge clk);
      exp_gnt = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
      total++;
      if (gnt !== exp_gnt || busy !== (m_owner >= 0)) begin
        bad++;
        $display("FAIL rand_gnt cycle %0d: gnt=%b busy=%b, required %b %b", c, gnt, busy, exp_gnt, m_owner >= 0);
      end
      if (m_owner >= 0) begin
        total++;
        if (sel !== 2'(m_owner) || y !== lane(in_data, m_owner)) begin
          bad++;
          $display("FAIL rand_sel cycle %0d: sel=%0d y=%h, required %0d %h", c, sel, y, m_owner, lane(in_data, m_owner));
        end
      end else begin
        total++;
        if (y !== '0) begin
          bad++;
          $display("FAIL rand_y_idle cycle %0d: got %h, required 0", c, y);
        end
      end
      total++;
      if (!$onehot0(gnt) || busy !== (|gnt) || gnt[sel] !== busy) begin
        bad++;
        $display("FAIL rand_invariant cycle %0d: gnt=%b sel=%0d busy=%b", c, gnt, sel, busy);
      end
      if (gnt != prev_gnt && gnt != 4'b0) begin
        total++;
        if ((gnt & req) == 4'b0) begin
          bad++;
          $display("FAIL rand_grant_req cycle %0d: gnt=%b req=%b, required a requesting owner", c, gnt, req);
        end
      end
      for (int b = 0; b < 4; b++) begin
        if (req[b] && !gnt[b]) wait_cnt[b]++;
        else wait_cnt[b] = 0;
        if (wait_cnt[b] > 3 * MH) begin
          total++;
          bad++;
          $display("FAIL rand_starve cycle %0d: requester %0d waited %0d, required <= %0d", c, b, wait_cnt[b], 3 * MH);
          wait_cnt[b] = 0;
        end
      end
      prev_gnt = gnt;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;
    in_data = '0;
    model_reset();
    test_reset();
    test_all_req();
    test_single();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
